// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Optional build macro: MUL_EARLY_EXIT_EN (see mul_unit.sv).
package mul_pkg;

   localparam int unsigned WIDTH_DEF  = 32;
   localparam int unsigned ADDR_W_DEF = 4;

   // r15 is the PC; writeback to it is suppressed
   localparam logic [3:0] PC_REG = 4'd15;

   localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StWb   = 2'd2
   } mul_state_e;

   // Iteration counter width for a given operand width
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: multiplicand, multiplier and product registers plus the step adder.
// The product register is preloaded with the accumulate addend, so the final step
// result is already a*b+acc modulo 2^WIDTH.
module mul_shift_add_dp
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] acc_init,
   output logic [WIDTH-1:0] prod_next,
   output logic             mult_next_zero
);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mult_q;
   logic [WIDTH-1:0] prod_q;
   logic [WIDTH-1:0] addend;

   // Step adder and early-termination detect for the current iteration
   always_comb begin
      addend         = mult_q[0] ? mcand_q : '0;
      prod_next      = prod_q + addend;
      mult_next_zero = ((mult_q >> 1) == '0);
   end

   // Operand latch on load, shift/accumulate on each step
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         mult_q  <= '0;
         prod_q  <= '0;
      end else if (load) begin
         mcand_q <= op_a;
         mult_q  <= op_b;
         prod_q  <= acc_init;
      end else if (step) begin
         mcand_q <= mcand_q << 1;
         mult_q  <= mult_q >> 1;
         prod_q  <= prod_next;
      end
   end

endmodule

// File: rtl/mul_unit.sv
// Iterative multiplier (MUL / MLA) producing registerFile write-port signals.
// Build macro MUL_EARLY_EXIT_EN: when defined, RUN ends as soon as the remaining
// multiplier bits are all zero; otherwise RUN always lasts WIDTH cycles.
module mul_unit
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic [WIDTH-1:0]  acc,
   input  logic              acc_en,
   input  logic [ADDR_W-1:0] dest,
   output logic              busy,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [WIDTH-1:0]  wd3,
   output logic              flag_n,
   output logic              flag_z,
   output logic              done
);

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

`ifdef MUL_EARLY_EXIT_EN
   localparam bit EarlyExit = 1'b1;
`else
   localparam bit EarlyExit = 1'b0;
`endif

   mul_state_e        state_q;
   logic [CntW-1:0]   count_q;
   logic [ADDR_W-1:0] dest_q;

   logic             load;
   logic             step;
   logic             last;
   logic [WIDTH-1:0] acc_init;
   logic [WIDTH-1:0] prod_next;
   logic             mult_next_zero;

   // Datapath control and end-of-run detection
   always_comb begin
      load     = (state_q == StIdle) && start;
      step     = (state_q == StRun);
      acc_init = acc_en ? acc : '0;
      last     = (count_q == CntMax) || (EarlyExit && mult_next_zero);
   end

   mul_shift_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk            (clk),
      .rst            (rst),
      .load           (load),
      .step           (step),
      .op_a           (op_a),
      .op_b           (op_b),
      .acc_init       (acc_init),
      .prod_next      (prod_next),
      .mult_next_zero (mult_next_zero)
   );

   // Control FSM with registered writeback outputs; wa3/wd3/flags hold outside WB
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         dest_q  <= '0;
         busy    <= 1'b0;
         we3     <= 1'b0;
         done    <= 1'b0;
         wa3     <= '0;
         wd3     <= '0;
         flag_n  <= 1'b0;
         flag_z  <= 1'b0;
      end else begin
         we3  <= 1'b0;
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  dest_q  <= dest;
                  count_q <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               count_q <= count_q + CntW'(1);
               if (last) begin
                  state_q <= StWb;
                  done    <= 1'b1;
                  we3     <= (dest_q != ADDR_W'(PC_REG));
                  wa3     <= dest_q;
                  wd3     <= prod_next;
                  flag_n  <= prod_next[WIDTH-1];
                  flag_z  <= (prod_next == '0);
               end
            end
            StWb: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative shift-add multiplier in the execute stage, directly downstream of registerFile.
- Takes operands from rd1/rd2, plus an optional accumulate value from a second read.
- Produces the registerFile write port signals (we3/wa3/wd3) for MUL and MLA writeback.
- Frees the single-cycle ALU from a 32x32 array multiplier.

Parameters:
- WIDTH, 32, operand/result width.
- ADDR_W, 4, register address width; matches ra/wa ports.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only when busy=0
- op_a  input  WIDTH  multiplicand (from rd1)
- op_b  input  WIDTH  multiplier (from rd2)
- acc  input  WIDTH  accumulate addend
- acc_en  input  1  1=MLA (a*b+acc), 0=MUL (a*b)
- dest  input  ADDR_W  destination register
- busy  output  1  high from the cycle after accept through the WB cycle inclusive
- we3  output  1  one-cycle registerFile write enable
- wa3  output  ADDR_W  write address
- wd3  output  WIDTH  write data
- flag_n  output  1  wd3[WIDTH-1], valid while we3 or done
- flag_z  output  1  wd3==0, valid while we3 or done
- done  output  1  one-cycle completion pulse, asserted even if the write is suppressed

Behaviour:
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, RUN, WB.
- IDLE:
  - start=1 latches op_a, op_b, acc/acc_en (acc forced to 0 when acc_en=0) and dest.
  - Clears the product register; count=0; next state RUN.
- RUN, per cycle:
  - If mult[0], prod += mcand.
  - mcand <<= 1; mult >>= 1; count++.
  - When count reaches WIDTH-1 (the 32nd RUN cycle), next state WB.
- Arithmetic: only the low WIDTH bits are kept; all arithmetic is modulo 2^WIDTH.
  - Result = (a*b + acc) mod 2^32.
  - The accumulate add is done on the final cycle or preloaded into prod; either is acceptable, but the result must match.
- WB (one cycle):
  - wd3 = result; wa3 = dest; done=1.
  - we3=1 unless dest==4'd15. r15 is the PC and is never written here, so we3 stays 0 for dest 15.
  - Next state IDLE.
- Latency: start sampled at edge k → we3/done high in the cycle after edge k+32, i.e. 33 cycles after acceptance.
- start while busy=1, including during the WB cycle, is ignored and not queued.
- Back-to-back: start may be accepted in the first IDLE cycle after WB.
- wa3/wd3 hold their last value outside WB; consumers must qualify with we3.
- Reset mid-operation:
  - Abort immediately to IDLE; no we3/done pulse.
  - Partial product is discarded.
- Operand inputs may change freely after acceptance; only latched copies are used.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the shifted multiplier becomes 0 after the current step, go to WB next cycle.
  - op_b=0 → 1 RUN cycle, we3 2 cycles after accept.
  - op_b=1 → also 1 RUN cycle.
  - Result is identical to the non-early-exit case.
- Undefined: fixed 32 RUN cycles regardless of operands.

Decomposition:
- Shared package mul_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, WB=2'd2).
  - WIDTH and ADDR_W defaults.
  - PC_REG=4'd15 constant.
  - Iteration count width $clog2(WIDTH).
- Sub-module: mul_shift_add_dp holds the mcand/mult/prod registers and the step adder. The FSM and writeback stay in mul_unit. A single flat module is also acceptable.

Test Plan:
- MUL: op_a=3, op_b=5, dest=2, acc_en=0 → exactly 33 cycles later we3=1, wa3=2, wd3=15, flag_z=0, flag_n=0 for one cycle; then busy=0.
- MLA wrap: op_a=32'hFFFF_FFFF, op_b=2, acc=1, acc_en=1, dest=7 → wd3=32'hFFFF_FFFF, flag_n=1.
- Overflow/zero: op_a=32'h0001_0000, op_b=32'h0001_0000, dest=4 → wd3=0, flag_z=1, we3=1.
- Suppressed PC write: op_a=2, op_b=2, dest=15 → done=1, we3=0 in the WB cycle.
- Busy rejection + reset:
  - start(6*7, dest=1) then start(9*9, dest=3) at cycle +5 → single writeback of 42 to r1.
  - Repeat with rst=1 at cycle +10 → no we3/done; busy=0 the cycle after reset.
- With MUL_EARLY_EXIT_EN: op_a=123, op_b=0 → we3 at cycle +2, wd3=0; op_b=8 → 4 RUN cycles, wd3=984.
